// File: rtl/compression_unit.sv
// Streaming RV32 -> RV32C compressor: swaps eligible 32-bit instructions for their
// 16-bit forms and packs the halfword stream little-endian into 32-bit output words.
module compression_unit #(
  parameter bit ENABLE_MEM_C = 1'b1,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             compress_en,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_word,
  output logic [CNT_W-1:0] cnt_in,
  output logic [CNT_W-1:0] cnt_comp,
  output logic             err,
  output logic             fsm_state
);

  // Handshake: a beat moves on a side when valid && ready in the same cycle; out_word
  // and out_valid hold steady while out_valid && !out_ready.
  typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_t;

  state_t      state, state_nxt;
  logic        hold_valid, hold_valid_nxt;
  logic [15:0] hold_data, hold_data_nxt;
  logic        out_valid_nxt;
  logic [31:0] out_word_nxt;
  logic        out_free, accept;
  logic        is_c;
  logic [15:0] code;

  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [4:0]  rd, rs1, rs2;
  logic [11:0] imm_i, imm_s;
  logic        imm_small, is_addi, is_add, lw_ok, sw_ok;

  assign opcode = in_inst[6:0];
  assign rd     = in_inst[11:7];
  assign funct3 = in_inst[14:12];
  assign rs1    = in_inst[19:15];
  assign rs2    = in_inst[24:20];
  assign funct7 = in_inst[31:25];
  assign imm_i  = in_inst[31:20];
  assign imm_s  = {in_inst[31:25], in_inst[11:7]};

  // Fits a 6-bit signed immediate when bits 11..5 are all copies of the sign.
  assign imm_small = (imm_i[11:5] == {7{imm_i[5]}});
  assign is_addi   = (opcode == 7'h13) && (funct3 == 3'b000);
  assign is_add    = (opcode == 7'h33) && (funct3 == 3'b000) && (funct7 == 7'h00);
  assign lw_ok     = (opcode == 7'h03) && (funct3 == 3'b010) && (rs1[4:3] == 2'b01) &&
                     (rd[4:3] == 2'b01) && (imm_i[11:7] == 5'd0) && (imm_i[1:0] == 2'b00);
  assign sw_ok     = (opcode == 7'h23) && (funct3 == 3'b010) && (rs1[4:3] == 2'b01) &&
                     (rs2[4:3] == 2'b01) && (imm_s[11:7] == 5'd0) && (imm_s[1:0] == 2'b00);

  always_comb begin
    is_c = 1'b0;
    code = 16'h0000;
    if (compress_en) begin
      if (is_addi && rd == 5'd0 && rs1 == 5'd0 && imm_i == 12'd0) begin
        is_c = 1'b1; code = 16'h0001;
      end else if (is_addi && rs1 == 5'd0 && rd != 5'd0 && imm_small) begin
        is_c = 1'b1; code = {3'b010, imm_i[5], rd, imm_i[4:0], 2'b01};
      end else if (is_addi && rd == rs1 && rd != 5'd0 && imm_i != 12'd0 && imm_small) begin
        is_c = 1'b1; code = {3'b000, imm_i[5], rd, imm_i[4:0], 2'b01};
      end else if (is_add && rs1 == 5'd0 && rd != 5'd0 && rs2 != 5'd0) begin
        is_c = 1'b1; code = {4'b1000, rd, rs2, 2'b10};
      end else if (is_add && rd == rs1 && rd != 5'd0 && rs2 != 5'd0) begin
        is_c = 1'b1; code = {4'b1001, rd, rs2, 2'b10};
      end else if (in_inst == 32'h0010_0073) begin
        is_c = 1'b1; code = 16'h9002;
      end else if (ENABLE_MEM_C && lw_ok) begin
        is_c = 1'b1;
        code = {3'b010, imm_i[5:3], rs1[2:0], imm_i[2], imm_i[6], rd[2:0], 2'b00};
      end else if (ENABLE_MEM_C && sw_ok) begin
        is_c = 1'b1;
        code = {3'b110, imm_s[5:3], rs1[2:0], imm_s[2], imm_s[6], rs2[2:0], 2'b00};
      end
    end
  end

  assign out_free  = !out_valid || out_ready;
  assign in_ready  = (state == RUN) && out_free;
  assign accept    = in_valid && in_ready;
  assign fsm_state = (state == FLUSH);

  always_comb begin
    state_nxt      = state;
    hold_valid_nxt = hold_valid;
    hold_data_nxt  = hold_data;
    out_valid_nxt  = out_valid && !out_ready;
    out_word_nxt   = out_word;
    if (accept) begin
      if (is_c) begin
        if (hold_valid) begin
          out_word_nxt   = {code, hold_data};
          out_valid_nxt  = 1'b1;
          hold_valid_nxt = 1'b0;
        end else begin
          hold_data_nxt  = code;
          hold_valid_nxt = 1'b1;
        end
      end else begin
        out_valid_nxt = 1'b1;
        if (hold_valid) begin
          // Word straddles the output boundary; its upper half becomes the new held half.
          out_word_nxt  = {in_inst[15:0], hold_data};
          hold_data_nxt = in_inst[31:16];
        end else begin
          out_word_nxt = in_inst;
        end
      end
      if (in_last && hold_valid_nxt) state_nxt = FLUSH;
    end else if (state == FLUSH && out_free) begin
      out_word_nxt   = {16'h0001, hold_data};
      out_valid_nxt  = 1'b1;
      hold_valid_nxt = 1'b0;
      state_nxt      = RUN;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= RUN;
      hold_valid <= 1'b0;
      hold_data  <= 16'h0000;
      out_valid  <= 1'b0;
      out_word   <= 32'h0000_0000;
    end else begin
      state      <= state_nxt;
      hold_valid <= hold_valid_nxt;
      hold_data  <= hold_data_nxt;
      out_valid  <= out_valid_nxt;
      out_word   <= out_word_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_in   <= '0;
      cnt_comp <= '0;
      err      <= 1'b0;
    end else if (accept) begin
      if (cnt_in != '1) cnt_in <= cnt_in + CNT_W'(1);
      if (is_c && cnt_comp != '1) cnt_comp <= cnt_comp + CNT_W'(1);
      if (in_inst[1:0] != 2'b11) err <= 1'b1;
    end
  end

endmodule
